// File: rtl/crc_arb_if.sv
`default_nettype none
// ============================================================================
// crc_arb_if : client request/response bundle and shared CRC device bus
// Revision   : 1.0
// ============================================================================
interface crc_arb_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]    req_rw;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_rdata;
  logic [31:0]        addr;
  logic [31:0]        data_wr;
  logic               RW;
  logic               Sel;
  logic [31:0]        data_rd;

  // arbiter side
  modport slave (
    input  req, lock, req_addr, req_wdata, req_rw, data_rd,
    output gnt, rsp_valid, rsp_rdata, addr, data_wr, RW, Sel
  );

  // environment side: requesters plus the CRC device
  modport master (
    output req, lock, req_addr, req_wdata, req_rw, data_rd,
    input  gnt, rsp_valid, rsp_rdata, addr, data_wr, RW, Sel
  );
endinterface
`default_nettype wire

// File: rtl/crc_arb.sv
`default_nettype none
// ============================================================================
// crc_arb : round-robin arbiter with bounded lock sharing one CRC device bus
// Revision: 1.0
// ============================================================================
module crc_arb #(
  parameter int NREQ    = 4,
  parameter int MAXLOCK = 8
) (
  input  wire       clk,
  input  wire       rst,
  crc_arb_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXLOCK + 1);
  localparam logic [CW-1:0] C_MAXLOCK = CW'(MAXLOCK);
  localparam logic [IW-1:0] C_LAST    = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [CW-1:0]   r_lock_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_rsp_valid;
  logic [31:0]     r_rsp_rdata;
  logic [31:0]     r_addr;
  logic [31:0]     r_data_wr;
  logic            r_rw;
  logic            r_sel;

  logic            w_lock_hold;
  logic            w_rr_found;
  logic [IW-1:0]   w_cand;
  logic [IW-1:0]   w_rr_idx;
  logic [IW-1:0]   w_win;
  logic [CW-1:0]   w_next_cnt;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_ptr_oh;
  logic [31:0]     w_sel_addr;
  logic [31:0]     w_sel_wdata;
  logic            w_sel_rw;

  // Round-robin scan starting just after the previous winner, wrapping.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_ptr;
    w_cand     = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = (w_cand == C_LAST) ? '0 : w_cand + IW'(1);
      if (!w_rr_found && bus.req[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_lock_hold = bus.lock[r_ptr] && bus.req[r_ptr] && (r_lock_cnt < C_MAXLOCK);
    w_win       = w_lock_hold ? r_ptr : w_rr_idx;
    if (w_lock_hold) begin
      w_next_cnt = r_lock_cnt + CW'(1);
    end else if (w_rr_idx != r_ptr) begin
      w_next_cnt = CW'(1);
    end else begin
      w_next_cnt = '0;
    end
  end

  always_comb begin
    w_win_oh    = '0;
    w_ptr_oh    = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_rw    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IW'(i)) begin
        w_win_oh[i] = 1'b1;
        w_sel_addr  = bus.req_addr[32*i +: 32];
        w_sel_wdata = bus.req_wdata[32*i +: 32];
        w_sel_rw    = bus.req_rw[i];
      end
      if (r_ptr == IW'(i)) begin
        w_ptr_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= C_LAST;
      r_lock_cnt  <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_addr      <= '0;
      r_data_wr   <= '0;
      r_rw        <= 1'b0;
      r_sel       <= 1'b0;
    end else begin
      // strobes default low so each is a single-cycle pulse
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_sel       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_state    <= S_ISSUE;
            r_sel      <= 1'b1;
            r_gnt      <= w_win_oh;
            r_ptr      <= w_win;
            r_lock_cnt <= w_next_cnt;
            r_addr     <= w_sel_addr;
            r_data_wr  <= w_sel_wdata;
            r_rw       <= w_sel_rw;
          end
        end
        S_ISSUE: begin
          if (r_rw) begin
            r_rsp_valid <= w_ptr_oh;
            r_rsp_rdata <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          r_rsp_rdata <= bus.data_rd;
          r_rsp_valid <= w_ptr_oh;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.addr      = r_addr;
  assign bus.data_wr   = r_data_wr;
  assign bus.RW        = r_rw;
  assign bus.Sel       = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_crc_arb.sv
`default_nettype none
// ============================================================================
// tb_crc_arb : directed vectors and multi-cycle sequences for crc_arb
// Revision   : 1.0
// ============================================================================
module tb_crc_arb;
  localparam int NREQ    = 4;
  localparam int MAXLOCK = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  crc_arb_if #(.NREQ(NREQ)) bus ();

  crc_arb #(.NREQ(NREQ), .MAXLOCK(MAXLOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dev_val(input logic [31:0] a);
    return (a == 32'h8) ? 32'h1234ABCD : ~a;
  endfunction

  // CRC device model: read data valid only in the cycle after a read Sel
  logic [31:0] r_dev_rd;
  always @(posedge clk) r_dev_rd <= (bus.Sel === 1'b1 && bus.RW === 1'b0) ? dev_val(bus.addr) : 32'h0;
  assign bus.data_rd = r_dev_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  typedef struct {
    int          idx;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[6];
  int   exp_seq[8];

  task automatic clear_inputs();
    bus.req    = '0;
    bus.lock   = '0;
    bus.req_rw = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[32*i +: 32]  = 32'hA000_0000 + 32'(i);
      bus.req_wdata[32*i +: 32] = 32'h5000_0000 + 32'(i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    bus.req_addr[32*v.idx +: 32]  = v.addr;
    bus.req_wdata[32*v.idx +: 32] = v.wdata;
    bus.req_rw[v.idx]             = v.rw;
    bus.req[v.idx]                = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d sel", n), 32'(bus.Sel), 32'h1);
    chk($sformatf("v%0d gnt", n), 32'(bus.gnt), 32'(oh(v.idx)));
    chk($sformatf("v%0d rw", n), 32'(bus.RW), 32'(v.rw));
    chk($sformatf("v%0d addr", n), bus.addr, v.addr);
    if (v.rw) chk($sformatf("v%0d data_wr", n), bus.data_wr, v.wdata);
    bus.req[v.idx] = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d sel_drop", n), 32'(bus.Sel), 32'h0);
    chk($sformatf("v%0d gnt_drop", n), 32'(bus.gnt), 32'h0);
    if (!v.rw) begin
      chk($sformatf("v%0d rsp_early", n), 32'(bus.rsp_valid), 32'h0);
      @(negedge clk);
    end
    chk($sformatf("v%0d rsp_valid", n), 32'(bus.rsp_valid), 32'(oh(v.idx)));
    chk($sformatf("v%0d rsp_rdata", n), bus.rsp_rdata, v.rdata);
    @(negedge clk);
    chk($sformatf("v%0d rsp_pulse", n), 32'(bus.rsp_valid), 32'h0);
    chk($sformatf("v%0d addr_hold", n), bus.addr, v.addr);
  endtask

  // Reqs were just presented at a negedge; writes expected back-to-back.
  task automatic check_grant_seq(input string tag, input int n);
    for (int c = 1; c <= 2 * n; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin
        chk($sformatf("%s gnt c%0d", tag, c), 32'(bus.gnt), 32'(oh(exp_seq[(c-1)/2])));
        chk($sformatf("%s sel c%0d", tag, c), 32'(bus.Sel), 32'h1);
      end else begin
        chk($sformatf("%s gnt c%0d", tag, c), 32'(bus.gnt), 32'h0);
        chk($sformatf("%s sel c%0d", tag, c), 32'(bus.Sel), 32'h0);
        chk($sformatf("%s rsp c%0d", tag, c), 32'(bus.rsp_valid), 32'(oh(exp_seq[(c-2)/2])));
      end
    end
  endtask

  initial begin
    vecs[0] = '{0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{2, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h1234_ABCD};
    vecs[2] = '{3, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, 32'h0000_0000};
    vecs[3] = '{1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'hFFFF_FFDF};
    vecs[4] = '{0, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h1234_ABCD};
    vecs[5] = '{2, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000};

    clear_inputs();
    do_reset();
    chk("rst sel", 32'(bus.Sel), 32'h0);
    chk("rst rw", 32'(bus.RW), 32'h0);
    chk("rst gnt", 32'(bus.gnt), 32'h0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst addr", bus.addr, 32'h0);
    chk("rst data_wr", bus.data_wr, 32'h0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Round-robin with all requesters writing continuously
    do_reset();
    bus.req_rw = '1;
    bus.req    = '1;
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 3; exp_seq[4] = 0;
    check_grant_seq("rr", 5);

    // Bounded lock: requester 1 locking against requester 3
    do_reset();
    bus.req_rw = '1;
    bus.lock   = 4'b0010;
    bus.req    = 4'b1010;
    exp_seq[0] = 1; exp_seq[1] = 1; exp_seq[2] = 1; exp_seq[3] = 3;
    exp_seq[4] = 1; exp_seq[5] = 1; exp_seq[6] = 1; exp_seq[7] = 3;
    check_grant_seq("lock", 8);

    // Reset asserted during RDWAIT
    do_reset();
    bus.req_addr[31:0] = 32'h0000_0040;
    bus.req[0]         = 1'b1;
    @(negedge clk);
    chk("mrst sel", 32'(bus.Sel), 32'h1);
    chk("mrst gnt", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("mrst rdwait rsp", 32'(bus.rsp_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst sel_after", 32'(bus.Sel), 32'h0);
    chk("mrst rsp_after", 32'(bus.rsp_valid), 32'h0);
    chk("mrst rdata_after", bus.rsp_rdata, 32'h0);
    chk("mrst addr_after", bus.addr, 32'h0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mrst no_rsp", 32'(bus.rsp_valid), 32'h0);
      chk("mrst no_sel", 32'(bus.Sel), 32'h0);
    end
    bus.req_rw = 4'b0011;
    bus.req    = 4'b0011;
    @(negedge clk);
    chk("mrst first_gnt", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst second_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/crc_arb.md
# crc_arb

Round-robin arbiter and bus sequencer that shares the single CRC device bus (addr, data_wr, RW, Sel, data_rd) among NREQ requesters. It selects one requester per transaction, drives a single-cycle Sel strobe to the CRC block and returns the write acknowledge or read data to the winning requester. Optional per-requester lock keeps back-to-back ownership for multi-word CRC sequences, bounded so that other requesters are not starved. The block sits between the NoC-side clients and the CRC block's device modport.

## Interface
- NREQ, 4, number of requesters (2..8)
- MAXLOCK, 8, maximum consecutive locked grants to one requester (>=1)
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous active-low reset
- req  in  NREQ  request per requester; held until its gnt bit is seen
- lock  in  NREQ  request to keep ownership for the next transaction
- req_addr  in  NREQ*32  address, requester i at bits [32i+31:32i]
- req_wdata  in  NREQ*32  write data, same packing
- req_rw  in  NREQ  1 = write, 0 = read
- gnt  out  NREQ  one-hot, one-cycle pulse when the command is issued
- rsp_valid  out  NREQ  one-hot, one-cycle pulse on write ack or read data return
- rsp_rdata  out  32  read data, valid with rsp_valid; 0 for writes
- addr  out  32  device address
- data_wr  out  32  device write data
- RW  out  1  device read = 0, write = 1
- Sel  out  1  device select strobe
- data_rd  in  32  device read data, valid the cycle after Sel

## Operation
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE: if any req is high, choose a winner w and register addr/data_wr/RW from w, Sel=1, gnt[w]=1. Go to ISSUE. With no req, stay in IDLE with Sel=0.
- ISSUE (Sel=1 for exactly this cycle):
  - Write: rsp_valid[w]=1 and rsp_rdata=0 are registered for the next cycle, then go to IDLE.
  - Read: go to RDWAIT.
- RDWAIT: capture data_rd into rsp_rdata, set rsp_valid[w]=1 for the next cycle, then go to IDLE.
- Winner selection:
  - Lock: if the previous winner p has lock[p]=1 and req[p]=1, and lock_cnt < MAXLOCK, then p wins again and lock_cnt increments.
  - Round-robin: otherwise, search from p+1 upward with wrap modulo NREQ. The first requester with req high wins. lock_cnt is set to 1 if the new winner differs from p; it is set to 0 if p is re-selected through the round-robin search.
- When lock_cnt reaches MAXLOCK, lock is ignored for one arbitration. If no other requester is active, p may still win through the round-robin search.
- addr, data_wr and RW hold their last values while Sel=0.
- Only the req bit is sampled in IDLE. A requester dropping req before its gnt is simply not considered.
- If req and lock are both low for every requester, the pointer p keeps its value.

## Timing
- Reset values: Sel=0, RW=0, addr=0, data_wr=0, gnt=0, rsp_valid=0, rsp_rdata=0, state=IDLE, p=NREQ-1 (so requester 0 wins first), lock_cnt=0.
- Request seen in IDLE at cycle T-1 gives Sel=1 and gnt[w]=1 in cycle T.
- Write: rsp_valid in cycle T+1. Earliest next Sel is T+2, so throughput is 1 write per 2 cycles.
- Read: data_rd is valid in T+1. rsp_valid and rsp_rdata appear in T+2. Earliest next Sel is T+3.
- gnt, Sel and rsp_valid are each high for exactly one cycle per transaction. Sel never stays high for two consecutive cycles.
- A requester may present its next command in the cycle after its gnt. It is considered at the next IDLE.
- Reset asserted in any state: on the next edge all outputs take their reset values. An in-flight transaction produces no rsp_valid and no further Sel.

## Test plan
- Single write: req[0]=1, req_rw[0]=1, addr=0x4, wdata=0xDEADBEEF. Required response: Sel, gnt[0], RW=1, addr=0x4, data_wr=0xDEADBEEF one cycle after the request; rsp_valid[0] on the next cycle with rsp_rdata=0.
- Single read: req[2], read, addr=0x8. The device model returns 0x1234ABCD the cycle after Sel. Required response: rsp_valid[2]=1 and rsp_rdata=0x1234ABCD two cycles after gnt[2].
- Round-robin: all four req held continuously with writes, lock=0 after reset. Required response: grant order 0,1,2,3,0, Sel spaced every 2 cycles.
- Lock limit: MAXLOCK=3, req[1] with lock[1]=1 and req[3] all held continuously. Required response: three consecutive grants to 1, then a grant to 3, then grants to 1 again.
- Reset mid-read: assert rst in the RDWAIT cycle. Required response: next edge gives Sel=0 and rsp_valid=0 with no response ever produced; after release, req[0] is granted first.
